// File: rtl/sfp_pkg.sv
// Shared definitions for the cross-core partial-sum reader: word widths, credit range and read FSM states.
package sfp_pkg;

    localparam int BW      = 8;
    localparam int BW_PSUM = 2 * BW + 4;
    localparam int SUM_W   = BW_PSUM + 4;

    localparam int                CRED_W   = 5;
    localparam logic [CRED_W-1:0] CRED_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CAP   = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sfp_sum_queue.sv
// Small synchronous FIFO for captured peer sums. The parent reserves a slot before every read,
// so there is deliberately no full guard here.
module sfp_sum_queue
    import sfp_pkg::*;
#(
    parameter int W     = SUM_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sfp_sum_reader.sv
// Consumer end of the cross-core partial-sum channel: credit tracking, peer FIFO read FSM and local queue.
// Optional SFP_SUM_ZERO_GUARD_EN forces a nonzero sum_in when the head's significant bits are all zero.
module sfp_sum_reader
    import sfp_pkg::*;
#(
    parameter int bw      = BW,
    parameter int bw_psum = 2 * bw + 4,
    parameter int RD_LAT  = 1,
    parameter int QDEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 peer_wr,
    input  logic [bw_psum+3:0]   peer_sum,
    output logic                 fifo_ext_rd,
    input  logic                 div,
    output logic [bw_psum+3:0]   sum_in,
    output logic                 sum_vld,
    output logic                 err_ovf,
    output logic                 err_udf
);

    localparam int               CW        = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0]    Q_FULL    = CW'(QDEPTH);
    localparam logic [1:0]       WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    rd_state_t            state;
    rd_state_t            state_nxt;
    logic [CRED_W-1:0]    credit;
    logic [1:0]           lat_cnt;
    logic [CW-1:0]        q_count;
    logic [bw_psum+3:0]   q_head;
    logic [bw_psum+3:0]   head_word;
    logic                 issue;
    logic                 push;
    logic                 pop;

    assign issue       = (state == ISSUE);
    assign push        = (state == CAP);
    assign sum_vld     = (q_count != '0);
    assign pop         = div && sum_vld;
    assign fifo_ext_rd = issue;
    assign head_word   = sum_vld ? q_head : '0;

    sfp_sum_queue #(
        .W     (bw_psum + 4),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (peer_sum),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count)
    );

    // A peer write and an issued read in the same cycle cancel; a write at full credit is lost and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit  <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (peer_wr && !issue) begin
                if (credit != CRED_MAX) begin
                    credit <= credit + 1'b1;
                end
            end else if (!peer_wr && issue) begin
                credit <= credit - 1'b1;
            end
            err_ovf <= err_ovf | (peer_wr && (credit == CRED_MAX));
            err_udf <= err_udf | (div && !sum_vld);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= (state == WAIT) ? lat_cnt + 1'b1 : 2'd0;
        end
    end

    // Only one read is ever outstanding, so in IDLE nothing is in flight and the queue count alone
    // decides whether a slot can be reserved.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (credit != '0 && q_count < Q_FULL) state_nxt = ISSUE;
            ISSUE: state_nxt = (RD_LAT == 1) ? CAP : WAIT;
            WAIT:  if (lat_cnt == WAIT_LAST) state_nxt = CAP;
            CAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SFP_SUM_ZERO_GUARD_EN
    always_comb begin
        sum_in = head_word;
        if (sum_vld && (head_word[bw_psum+3:7] == '0)) begin
            sum_in    = '0;
            sum_in[7] = 1'b1;
        end
    end
`else
    assign sum_in = head_word;
`endif

endmodule

// File: tb/tb_sfp_sum_reader.sv
// Directed bench for sfp_sum_reader with a behavioural peer FIFO (RD_LAT = 1).
module tb_sfp_sum_reader;
    import sfp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              peer_wr;
    logic [SUM_W-1:0]  peer_sum;
    logic              fifo_ext_rd;
    logic              div;
    logic [SUM_W-1:0]  sum_in;
    logic              sum_vld;
    logic              err_ovf;
    logic              err_udf;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [SUM_W-1:0]  peer_words [$];
    int                rd_idx;
    int                rd_count = 0;
    int                rd_base;
    logic [SUM_W-1:0]  exp_words [6];

    sfp_sum_reader dut (
        .clk         (clk),
        .reset       (reset),
        .peer_wr     (peer_wr),
        .peer_sum    (peer_sum),
        .fifo_ext_rd (fifo_ext_rd),
        .div         (div),
        .sum_in      (sum_in),
        .sum_vld     (sum_vld),
        .err_ovf     (err_ovf),
        .err_udf     (err_udf)
    );

    always #5 clk = ~clk;

    // Peer FIFO model: words written before a reset are abandoned along with the reader's state.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx   <= peer_words.size();
            peer_sum <= '0;
        end else if (fifo_ext_rd) begin
            peer_sum <= (rd_idx < peer_words.size()) ? peer_words[rd_idx] : '0;
            rd_idx   <= rd_idx + 1;
            rd_count <= rd_count + 1;
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [SUM_W-1:0] word);
        peer_words.push_back(word);
        peer_wr = 1'b1;
        tick();
        peer_wr = 1'b0;
    endtask

    task automatic popHead(input string tag, input logic [SUM_W-1:0] exp);
        checkOutput(tag, 32'(sum_in), 32'(exp));
        div = 1'b1;
        tick();
        div = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        peer_wr = 1'b0;
        div     = 1'b0;
        tick(2);
        checkOutput("rst_vld",    32'(sum_vld),     32'd0);
        checkOutput("rst_sum",    32'(sum_in),      32'd0);
        checkOutput("rst_rd",     32'(fifo_ext_rd), 32'd0);
        checkOutput("rst_ovf",    32'(err_ovf),     32'd0);
        checkOutput("rst_udf",    32'(err_udf),     32'd0);
        reset = 1'b1;
        tick(2);

        // Single sum round trip
        applyStimulus(24'h000A80);
        checkOutput("t2_rd_lo",   32'(fifo_ext_rd), 32'd0);
        tick();
        checkOutput("t2_rd_hi",   32'(fifo_ext_rd), 32'd1);
        tick();
        checkOutput("t2_rd_once", 32'(fifo_ext_rd), 32'd0);
        checkOutput("t2_vld_lo",  32'(sum_vld),     32'd0);
        tick();
        checkOutput("t2_vld_hi",  32'(sum_vld),     32'd1);
        checkOutput("t2_sum",     32'(sum_in),      32'h000A80);
        div = 1'b1;
        tick();
        div = 1'b0;
        checkOutput("t2_vld_pop", 32'(sum_vld),     32'd0);
        checkOutput("t2_credit",  32'(dut.credit),  32'd0);

        // Backpressure: six writes, only four slots
        exp_words = '{24'h123456, 24'hABCDEF, 24'h800000, 24'h0F0F80, 24'hFFFFFF, 24'h314159};
        rd_base = rd_count;
        for (int k = 0; k < 6; k++) applyStimulus(exp_words[k]);
        tick(30);
        checkOutput("t3_reads4",  32'(rd_count - rd_base), 32'd4);
        checkOutput("t3_credit2", 32'(dut.credit),  32'd2);
        checkOutput("t3_qfull",   32'(dut.q_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            popHead("t3_order", exp_words[k]);
            tick(4);
        end
        tick(20);
        checkOutput("t3_reads6",  32'(rd_count - rd_base), 32'd6);
        checkOutput("t3_credit0", 32'(dut.credit),  32'd0);
        checkOutput("t3_q2",      32'(dut.q_count), 32'd2);
        popHead("t3_tail4", exp_words[4]);
        popHead("t3_tail5", exp_words[5]);
        checkOutput("t3_empty",   32'(sum_vld),     32'd0);

        // Write on ISSUE, div on CAP
        applyStimulus(24'h111180);
        tick(6);
        checkOutput("t4_q1",      32'(dut.q_count), 32'd1);
        applyStimulus(24'h222280);
        tick();
        checkOutput("t4_issue",   32'(fifo_ext_rd), 32'd1);
        checkOutput("t4_cred_is", 32'(dut.credit),  32'd1);
        peer_words.push_back(24'h333380);
        peer_wr = 1'b1;
        tick();
        peer_wr = 1'b0;
        checkOutput("t4_cred_cap", 32'(dut.credit), 32'd1);
        checkOutput("t4_q_cap",   32'(dut.q_count), 32'd1);
        div = 1'b1;
        tick();
        div = 1'b0;
        checkOutput("t4_q_same",  32'(dut.q_count), 32'd1);
        checkOutput("t4_head",    32'(sum_in),      32'h222280);
        checkOutput("t4_ovf",     32'(err_ovf),     32'd0);
        checkOutput("t4_udf",     32'(err_udf),     32'd0);
        tick(6);
        popHead("t4_popY", 24'h222280);
        popHead("t4_popZ", 24'h333380);
        checkOutput("t4_empty",   32'(sum_vld),     32'd0);

        // Asynchronous reset in the middle of a read
        for (int k = 0; k < 9; k++) applyStimulus(24'h400000 + 24'(k));
        tick(40);
        checkOutput("t1_q4",      32'(dut.q_count), 32'd4);
        checkOutput("t1_cred5",   32'(dut.credit),  32'd5);
        div = 1'b1;
        tick(2);
        checkOutput("t1_midread", 32'(fifo_ext_rd), 32'd1);
        checkOutput("t1_q2",      32'(dut.q_count), 32'd2);
        reset = 1'b0;
        div   = 1'b0;
        #1;
        checkOutput("t1_a_rd",    32'(fifo_ext_rd), 32'd0);
        checkOutput("t1_a_vld",   32'(sum_vld),     32'd0);
        checkOutput("t1_a_sum",   32'(sum_in),      32'd0);
        checkOutput("t1_a_cred",  32'(dut.credit),  32'd0);
        tick();
        checkOutput("t1_e_rd",    32'(fifo_ext_rd), 32'd0);
        checkOutput("t1_e_state", 32'(dut.state),   32'(IDLE));
        reset = 1'b1;
        tick(2);

        // Credit overflow with the queue full
        for (int k = 0; k < 4; k++) applyStimulus(24'h500080 + 24'(k));
        tick(20);
        checkOutput("t5_qfull",   32'(dut.q_count), 32'd4);
        for (int k = 0; k < 16; k++) applyStimulus(24'h600080);
        checkOutput("t5_cred16",  32'(dut.credit),  32'd16);
        checkOutput("t5_no_ovf",  32'(err_ovf),     32'd0);
        applyStimulus(24'h700080);
        checkOutput("t5_ovf",     32'(err_ovf),     32'd1);
        checkOutput("t5_hold16",  32'(dut.credit),  32'd16);
        tick(3);
        checkOutput("t5_sticky",  32'(err_ovf),     32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick(2);
        checkOutput("t5_clr_ovf", 32'(err_ovf),     32'd0);
        div = 1'b1;
        tick();
        div = 1'b0;
        checkOutput("t5_udf",     32'(err_udf),     32'd1);
        checkOutput("t5_udf_sum", 32'(sum_in),      32'd0);
        checkOutput("t5_udf_vld", 32'(sum_vld),     32'd0);

        // Small head word: guarded build lifts it to 0x80
        applyStimulus(24'h00007F);
        tick(6);
        checkOutput("t6_vld",     32'(sum_vld),     32'd1);
`ifdef SFP_SUM_ZERO_GUARD_EN
        popHead("t6_guard", 24'h000080);
`else
        popHead("t6_raw",   24'h00007F);
`endif
        applyStimulus(24'h000180);
        tick(6);
        popHead("t6_pass", 24'h000180);
        checkOutput("t6_empty",   32'(sum_in),      32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
